// File: rtl/bridge_rom_downloader_if.sv
// bridge_rom_downloader_if: bridge write bus plus halfword download handshake
interface bridge_rom_downloader_if #(
  parameter int ADDR_WIDTH = 24
);
  logic                  bridge_wr;
  logic [31:0]           bridge_addr;
  logic [31:0]           bridge_data;
  logic                  bridge_done;
  logic                  dl_valid;
  logic                  dl_ready;
  logic [ADDR_WIDTH-1:0] dl_addr;
  logic [15:0]           dl_data;
  logic                  dl_busy;
  logic                  dl_done;
  logic                  overflow;
  logic [21:0]           hw_count;
  modport master (
    output bridge_wr, bridge_addr, bridge_data, bridge_done, dl_ready,
    input  dl_valid, dl_addr, dl_data, dl_busy, dl_done, overflow, hw_count
  );
  modport slave (
    input  bridge_wr, bridge_addr, bridge_data, bridge_done, dl_ready,
    output dl_valid, dl_addr, dl_data, dl_busy, dl_done, overflow, hw_count
  );
endinterface

// File: rtl/bridge_rom_downloader.sv
// bridge_rom_downloader: buffers bridge data-slot writes and replays them as 16-bit ROM loader writes
module bridge_rom_downloader #(
  parameter logic [7:0] WINDOW     = 8'h00,
  parameter int         FIFO_DEPTH = 16,
  parameter int         ADDR_WIDTH = 24
) (
  input logic clk,
  input logic reset,
  bridge_rom_downloader_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_WIDTH + 30;
  localparam logic [PW:0] ONE = 1;
  localparam logic [1:0] IDLE = 2'd0, LO = 2'd1, HI = 2'd2;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW:0] wp, rp, rp_n;
  logic [1:0] state;
  logic [EW-1:0] head, nxt;
  logic empty, full, cap, hs, pop, push, more;
  logic dl_valid, dl_done, overflow;
  logic [ADDR_WIDTH-1:0] dl_addr;
  logic [15:0] dl_data;
  logic [21:0] hw_count;
  // Head entry stays in the FIFO until its HI halfword is accepted; nxt feeds the bubble-free reload.
  always_comb begin
    rp_n = rp + ONE;
    head = mem[rp[PW-1:0]];
    nxt = mem[rp_n[PW-1:0]];
    empty = wp == rp;
    full = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    cap = bus.bridge_wr && bus.bridge_addr[31:24] == WINDOW;
    hs = dl_valid && bus.dl_ready;
    pop = hs && state == HI;
    push = cap && (!full || pop);
    more = wp != rp_n;
  end
  // Storage array has no reset so it can map onto plain RAM.
  always_ff @(posedge clk)
    if (push) mem[wp[PW-1:0]] <= {bus.bridge_addr[ADDR_WIDTH-1:2], bus.bridge_data};
  // Pointers, status flags and the halfword output FSM.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      state <= IDLE;
      dl_valid <= 1'b0;
      dl_addr <= '0;
      dl_data <= '0;
      dl_done <= 1'b0;
      overflow <= 1'b0;
      hw_count <= '0;
    end else begin
      if (push) wp <= wp + ONE;
      if (pop) rp <= rp_n;
      if (cap && full && !pop) overflow <= 1'b1;
      if (hs) hw_count <= hw_count + 22'd1;
      dl_done <= cap ? 1'b0 : (bus.bridge_done && empty && state == IDLE) ? 1'b1 : dl_done;
      case (state)
        IDLE: if (!empty) begin
          dl_addr <= {head[EW-1:32], 2'b00};
          dl_data <= head[15:0];
          dl_valid <= 1'b1;
          state <= LO;
        end
        LO: if (hs) begin
          dl_addr <= dl_addr + ADDR_WIDTH'(2);
          dl_data <= head[31:16];
          state <= HI;
        end
        HI: if (hs) begin
          if (more) begin
            dl_addr <= {nxt[EW-1:32], 2'b00};
            dl_data <= nxt[15:0];
            state <= LO;
          end else begin
            dl_valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          dl_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  assign bus.dl_valid = dl_valid;
  assign bus.dl_addr = dl_addr;
  assign bus.dl_data = dl_data;
  assign bus.dl_busy = !empty || state != IDLE;
  assign bus.dl_done = dl_done;
  assign bus.overflow = overflow;
  assign bus.hw_count = hw_count;
endmodule

// File: tb/tb_bridge_rom_downloader.sv
// tb_bridge_rom_downloader: scoreboard bench for the bridge ROM downloader
module tb_bridge_rom_downloader;
  typedef struct {
    logic        hi;
    logic [23:0] addr;
    logic [15:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int pops = 0;
  int exp_hw = 0;
  int hw_base = 0;
  int acc;
  logic exp_ovf = 1'b0;
  logic [21:0] hw_before;
  exp_t exp_q[$];
  bridge_rom_downloader_if #(.ADDR_WIDTH(24)) bus();
  bridge_rom_downloader #(.WINDOW(8'h00), .FIFO_DEPTH(16), .ADDR_WIDTH(24)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  // Acceptance is decided at the capture edge, after any pop seen on that edge's handshake.
  task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
    logic [23:0] base;
    bus.bridge_wr = 1'b1;
    bus.bridge_addr = a;
    bus.bridge_data = d;
    @(posedge clk);
    if (a[31:24] == 8'h00) begin
      if (pushes - pops < 16) begin
        base = {a[23:2], 2'b00};
        exp_q.push_back('{1'b0, base, d[15:0]});
        exp_q.push_back('{1'b1, base + 24'd2, d[31:16]});
        pushes++;
      end else exp_ovf = 1'b1;
    end
    #1 bus.bridge_wr = 1'b0;
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.dl_busy) && n < 500) begin
      step(1);
      n++;
    end
    check("drain_timeout", n < 500, 1);
    check("drain_hw", bus.hw_count, 22'(exp_hw - hw_base));
  endtask
  // Scoreboard: every accepted halfword must match the next expected entry.
  always @(negedge clk)
    if (!reset && bus.dl_valid && bus.dl_ready) begin
      if (exp_q.size() == 0) check("spurious_hs", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("hs_addr", bus.dl_addr, e.addr);
        check("hs_data", bus.dl_data, e.data);
        if (e.hi) pops++;
      end
      exp_hw++;
    end
  initial begin
    bus.bridge_wr = 1'b0;
    bus.bridge_addr = '0;
    bus.bridge_data = '0;
    bus.bridge_done = 1'b0;
    bus.dl_ready = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("rst_valid", bus.dl_valid, 0);
    check("rst_addr", bus.dl_addr, 0);
    check("rst_data", bus.dl_data, 0);
    check("rst_busy", bus.dl_busy, 0);
    check("rst_done", bus.dl_done, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_hw", bus.hw_count, 0);
    step(2);
    reset = 1'b0;
    step(1);
    wr_word(32'h2000_0000, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      check("win_valid", bus.dl_valid, 0);
      check("win_busy", bus.dl_busy, 0);
      step(1);
    end
    check("win_hw", bus.hw_count, 0);
    wr_word(32'h0000_0010, 32'hAABB_CCDD);
    check("lat_n_valid", bus.dl_valid, 0);
    check("lat_n_busy", bus.dl_busy, 1);
    step(1);
    check("lat_n1_valid", bus.dl_valid, 1);
    check("lat_n1_addr", bus.dl_addr, 24'h000010);
    check("lat_n1_data", bus.dl_data, 16'hCCDD);
    step(1);
    check("lat_n2_valid", bus.dl_valid, 1);
    check("lat_n2_addr", bus.dl_addr, 24'h000012);
    check("lat_n2_data", bus.dl_data, 16'hAABB);
    step(1);
    check("lat_n3_valid", bus.dl_valid, 0);
    check("lat_n3_hw", bus.hw_count, 2);
    wr_word(32'h00FF_FFFE, 32'h0102_0304);
    drain();
    bus.dl_ready = 1'b0;
    wr_word(32'h0000_0010, 32'hAABB_CCDD);
    step(1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", bus.dl_valid, 1);
      check("bp_addr", bus.dl_addr, 24'h000010);
      check("bp_data", bus.dl_data, 16'hCCDD);
      step(1);
    end
    bus.dl_ready = 1'b1;
    drain();
    bus.dl_ready = 1'b0;
    hw_before = bus.hw_count;
    acc = pushes;
    for (int i = 0; i < 18; i++) begin
      wr_word(32'h0000_1000 + 32'(i * 4), $urandom);
      check("ovf_flag", bus.overflow, exp_ovf);
    end
    check("ovf_set", bus.overflow, 1);
    acc = pushes - acc;
    bus.dl_ready = 1'b1;
    drain();
    check("ovf_count", bus.hw_count, hw_before + 22'(acc * 2));
    check("ovf_sticky", bus.overflow, 1);
    for (int i = 0; i < 4; i++) wr_word(32'h0000_2000 + 32'(i * 4), $urandom);
    drain();
    check("done_pre", bus.dl_done, 0);
    bus.bridge_done = 1'b1;
    step(1);
    bus.bridge_done = 1'b0;
    check("done_set", bus.dl_done, 1);
    step(2);
    check("done_hold", bus.dl_done, 1);
    wr_word(32'h0000_3000, 32'hDEAD_BEEF);
    check("done_clr", bus.dl_done, 0);
    drain();
    bus.dl_ready = 1'b0;
    bus.bridge_done = 1'b1;
    wr_word(32'h0000_3004, 32'hCAFE_F00D);
    check("done_race", bus.dl_done, 0);
    wr_word(32'h0000_3008, 32'h5555_AAAA);
    step(3);
    check("done_busy", bus.dl_done, 0);
    bus.dl_ready = 1'b1;
    begin
      int n = 0;
      while (bus.dl_busy && n < 100) begin
        step(1);
        n++;
      end
      check("done_wait", n < 100, 1);
    end
    check("done_last_hs", bus.dl_done, 0);
    check("done_q", exp_q.size(), 0);
    step(1);
    check("done_after", bus.dl_done, 1);
    bus.bridge_done = 1'b0;
    bus.dl_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr_word(32'h0000_4000 + 32'(i * 4), $urandom);
    bus.dl_ready = 1'b1;
    step(1);
    bus.dl_ready = 1'b0;
    check("mid_hi_addr", bus.dl_addr, 24'h004002);
    #2 reset = 1'b1;
    #1;
    check("mid_valid", bus.dl_valid, 0);
    check("mid_addr", bus.dl_addr, 0);
    check("mid_data", bus.dl_data, 0);
    check("mid_busy", bus.dl_busy, 0);
    check("mid_ovf", bus.overflow, 0);
    check("mid_hw", bus.hw_count, 0);
    exp_q.delete();
    pushes = pops;
    hw_base = exp_hw;
    exp_ovf = 1'b0;
    step(1);
    reset = 1'b0;
    bus.dl_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("post_valid", bus.dl_valid, 0);
      check("post_busy", bus.dl_busy, 0);
      step(1);
    end
    wr_word(32'h0000_5000, 32'h8765_4321);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
